// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 3-stage pre-add / multiply / add-accumulate with sticky overflow.
// Ports: clk, rst_n, in_valid/in_ready, a, d, b, c, pre_sel, z_sel, sub, ovf_clr,
//        out_valid, p, ovf, p_zero, out_ready (single global stall).
module dsp_mac_pipe #(
  parameter int A_W = 25,
  parameter int B_W = 18,
  parameter int P_W = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [A_W-1:0] a,
  input  logic signed [A_W-1:0] d,
  input  logic signed [B_W-1:0] b,
  input  logic signed [P_W-1:0] c,
  input  logic [1:0]            pre_sel,
  input  logic [1:0]            z_sel,
  input  logic                  sub,
  output logic                  out_valid,
  output logic signed [P_W-1:0] p,
  output logic                  ovf,
  output logic                  p_zero,
  input  logic                  ovf_clr,
  input  logic                  out_ready
);

  localparam int PR_W = A_W + 1;
  localparam int M_W  = A_W + 1 + B_W;

  if (M_W > P_W) begin : g_width_chk
    $error("dsp_mac_pipe: P_W must be >= A_W+1+B_W");
  end

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // one extra bit keeps D+A, D-A and -A(min) exact
  logic signed [PR_W-1:0] a_x, d_x, pre_d;
  assign a_x = PR_W'(a);
  assign d_x = PR_W'(d);

  always_comb begin
    pre_d = a_x;
    unique case (pre_sel)
      2'b00: pre_d = a_x;
      2'b01: pre_d = d_x + a_x;
      2'b10: pre_d = d_x - a_x;
      2'b11: pre_d = -a_x;
    endcase
  end

  logic                   v1;
  logic signed [PR_W-1:0] pre_q;
  logic signed [B_W-1:0]  b_q;
  logic signed [P_W-1:0]  c1_q;
  logic [1:0]             z1_q;
  logic                   sub1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      pre_q  <= '0;
      b_q    <= '0;
      c1_q   <= '0;
      z1_q   <= '0;
      sub1_q <= 1'b0;
    end else if (en) begin
      v1     <= in_valid;
      pre_q  <= pre_d;
      b_q    <= b;
      c1_q   <= c;
      z1_q   <= z_sel;
      sub1_q <= sub;
    end
  end

  logic signed [M_W-1:0] prod;
  assign prod = pre_q * b_q;

  logic                  v2;
  logic signed [P_W-1:0] m_q;
  logic signed [P_W-1:0] c2_q;
  logic [1:0]            z2_q;
  logic                  sub2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      m_q    <= '0;
      c2_q   <= '0;
      z2_q   <= '0;
      sub2_q <= 1'b0;
    end else if (en) begin
      v2     <= v1;
      m_q    <= P_W'(prod);
      c2_q   <= c1_q;
      z2_q   <= z1_q;
      sub2_q <= sub1_q;
    end
  end

  // accumulate reads p itself, which always holds the last valid result
  logic signed [P_W-1:0] z_d;
  always_comb begin
    z_d = '0;
    unique case (z2_q)
      2'b01:   z_d = c2_q;
      2'b10:   z_d = p;
      default: z_d = '0;
    endcase
  end

  logic signed [P_W:0] zx, mx, s;
  logic                s_ovf;
  assign zx    = (P_W+1)'(z_d);
  assign mx    = (P_W+1)'(m_q);
  assign s     = sub2_q ? zx - mx : zx + mx;
  assign s_ovf = s[P_W] ^ s[P_W-1];

  logic upd;
  assign upd = en && v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= '0;
      p_zero    <= 1'b1;
    end else if (en) begin
      out_valid <= v2;
      if (v2) begin
        p      <= s[P_W-1:0];
        p_zero <= (s[P_W-1:0] == '0);
      end
    end
  end

  // a fresh overflow beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (upd && s_ovf) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed checks of dsp_mac_pipe at default widths.
// Drives inputs 1ns after rising edges and samples there too.
module tb_dsp_mac_pipe;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready;
  logic signed [24:0] a, d;
  logic signed [17:0] b;
  logic signed [47:0] c;
  logic [1:0]         pre_sel, z_sel;
  logic               sub, out_valid, ovf, p_zero;
  logic               ovf_clr, out_ready;
  logic signed [47:0] p;

  int total = 0;
  int bad   = 0;

  localparam longint PMAX = (64'sd1 <<< 47) - 1;
  localparam longint PMIN = -(64'sd1 <<< 47);

  always #5 clk = ~clk;

  dsp_mac_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .d(d), .b(b), .c(c),
    .pre_sel(pre_sel), .z_sel(z_sel), .sub(sub),
    .out_valid(out_valid), .p(p), .ovf(ovf),
    .p_zero(p_zero), .ovf_clr(ovf_clr),
    .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic set_beat(input longint av, input longint dv,
                          input longint bv, input longint cv,
                          input logic [1:0] ps,
                          input logic [1:0] zs,
                          input logic sb);
    in_valid = 1'b1;
    a = 25'(av);
    d = 25'(dv);
    b = 18'(bv);
    c = 48'(cv);
    pre_sel = ps;
    z_sel = zs;
    sub = sb;
  endtask

  longint acc_exp [5];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0;
    a = '0; d = '0; b = '0; c = '0;
    pre_sel = '0; z_sel = '0; sub = 1'b0;
    ovf_clr = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_p", p, 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_p_zero", longint'(p_zero), 1);
    chk("rst_in_ready", longint'(in_ready), 1);
    rst_n = 1'b1;
    tick();

    // multiply-add: 3*-4 + 100
    set_beat(3, 0, -4, 100, 2'b00, 2'b01, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("madd_early_valid", longint'(out_valid), 0);
    tick();
    chk("madd_valid", longint'(out_valid), 1);
    chk("madd_p", p, 88);
    tick();
    chk("madd_valid_drop", longint'(out_valid), 0);
    chk("madd_p_hold", p, 88);

    // pre-adder D-A and -A(min)
    set_beat(3, 10, 5, 0, 2'b10, 2'b00, 1'b0);
    tick();
    set_beat(-(64'sd1 <<< 24), 0, 1, 0, 2'b11, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_dma_p", p, 35);
    tick();
    chk("pre_neg_min_p", p, 64'sd1 <<< 24);
    chk("pre_neg_min_pz", longint'(p_zero), 0);

    // clear p then accumulate 1..4 times 2
    acc_exp = '{0, 2, 6, 12, 20};
    for (int i = 0; i < 8; i++) begin
      if (i == 0)
        set_beat(0, 0, 0, 0, 2'b00, 2'b00, 1'b0);
      else if (i < 5)
        set_beat(i, 0, 2, 0, 2'b00, 2'b10, 1'b0);
      else
        in_valid = 1'b0;
      tick();
      if (i >= 2 && i <= 6) begin
        chk($sformatf("acc_p%0d", i - 2), p, acc_exp[i-2]);
        chk($sformatf("acc_v%0d", i - 2),
            longint'(out_valid), 1);
      end
      if (i == 2)
        chk("acc_pz", longint'(p_zero), 1);
    end

    // backpressure with three beats in flight
    set_beat(7, 0, 1, 0, 2'b00, 2'b00, 1'b0);
    tick();
    set_beat(8, 0, 1, 0, 2'b00, 2'b00, 1'b0);
    tick();
    set_beat(9, 0, 1, 0, 2'b00, 2'b00, 1'b0);
    tick();
    chk("bp_first_p", p, 7);
    out_ready = 1'b0;
    set_beat(10, 0, 1, 0, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_rdy%0d", i), longint'(in_ready), 0);
      chk($sformatf("bp_p%0d", i), p, 7);
      chk($sformatf("bp_v%0d", i), longint'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", longint'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_p8", p, 8);
    tick();
    chk("bp_p9", p, 9);
    tick();
    chk("bp_p10", p, 10);
    chk("bp_v10", longint'(out_valid), 1);
    tick();
    chk("bp_drain_v", longint'(out_valid), 0);

    // overflow on accumulate
    set_beat(0, 0, 0, PMAX, 2'b00, 2'b01, 1'b0);
    tick();
    set_beat(1, 0, 1, 0, 2'b00, 2'b10, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("ovf_pre_p", p, PMAX);
    chk("ovf_pre_flag", longint'(ovf), 0);
    tick();
    chk("ovf_wrap_p", p, PMIN);
    chk("ovf_set", longint'(ovf), 1);
    tick();
    chk("ovf_sticky", longint'(ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", longint'(ovf), 0);

    // negative overflow while clear is held: set wins
    set_beat(1, 0, 1, 0, 2'b00, 2'b10, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_setwins_p", p, PMAX);
    chk("ovf_setwins", longint'(ovf), 1);

    // reset with two beats in flight
    set_beat(5, 0, 1, 0, 2'b00, 2'b00, 1'b0);
    tick();
    set_beat(6, 0, 1, 0, 2'b00, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_v", longint'(out_valid), 0);
    chk("mrst_p", p, 0);
    chk("mrst_pz", longint'(p_zero), 1);
    chk("mrst_ovf", longint'(ovf), 0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mrst_stale%0d", i),
          longint'(out_valid), 0);
    end
    set_beat(2, 0, 3, 0, 2'b00, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mrst_new_v", longint'(out_valid), 1);
    chk("mrst_new_p", p, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
